// File: rtl/car_alarm_display_if.sv
// Door sensor, acknowledge button and display signals of the car alarm display path.
// The master drives the sensors and buttons; the slave drives segment and alarm.
interface car_alarm_display_if;
  logic       front1;
  logic       front2;
  logic       back1;
  logic       back2;
  logic       trunk;
  logic       bttnL;
  logic       bttnR;
  logic       bttnU;
  logic       bttnD;
  logic       bttnC;
  logic [6:0] segment;
  logic       alarm;

  modport master (
    output front1, front2, back1, back2, trunk,
    output bttnL, bttnR, bttnU, bttnD, bttnC,
    input  segment, alarm
  );

  modport slave (
    input  front1, front2, back1, back2, trunk,
    input  bttnL, bttnR, bttnU, bttnD, bttnC,
    output segment, alarm
  );
endinterface

// File: rtl/car_alarm_display.sv
// Latches newly opened doors as pending and shows them round-robin on an active-low 7-seg bus.
// Define CAR_ALARM_BLINK_EN to blank the code during the second half of each dwell.
module car_alarm_display #(
  parameter int unsigned DWELL = 16
) (
  input logic                clk,
  input logic                rst,
  car_alarm_display_if.slave bus
);

  localparam int unsigned CntW = $clog2(DWELL);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t       CntLast  = cnt_t'(DWELL - 1);
  localparam logic [6:0] SegBlank = 7'b1111111;
`ifdef CAR_ALARM_BLINK_EN
  localparam cnt_t       CntHalf  = cnt_t'(DWELL / 2);
`endif

  logic [4:0] door, btn, door_q, btn_q, door_rise, btn_rise;
  logic [4:0] pend_q, pend_d;
  logic [2:0] idx_q, idx_d, idx_next;
  cnt_t       cnt_q, cnt_d;
  logic [6:0] seg_q, seg_d, code;
  logic       cur_pend;

  assign door = {bus.trunk, bus.back2, bus.back1, bus.front2, bus.front1};
  assign btn  = {bus.bttnC, bus.bttnD, bus.bttnU, bus.bttnR, bus.bttnL};

  assign door_rise = door & ~door_q;
  assign btn_rise  = btn & ~btn_q;
  // A door rise on the same bit overrides its acknowledge.
  assign pend_d    = (pend_q | door_rise) & ~(btn_rise & ~door_rise);

  assign cur_pend  = pend_q[idx_q];

  // First pending door after idx_q, scanning cyclically; wraps back to idx_q itself.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] cand;
    logic       found;
    idx_next = idx_q;
    found    = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sum  = {1'b0, idx_q} + 4'(k);
      cand = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
      if (!found && pend_q[cand]) begin
        idx_next = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (pend_q == 5'b0) begin
      cnt_d = '0;
    end else if (!cur_pend || cnt_q == CntLast) begin
      idx_d = idx_next;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  always_comb begin
    case (idx_q)
      3'd0:    code = 7'b0001110;
      3'd1:    code = 7'b0000011;
      3'd2:    code = 7'b0000110;
      3'd3:    code = 7'b1000110;
      3'd4:    code = 7'b0100001;
      default: code = SegBlank;
    endcase
  end

  always_comb begin
    seg_d = cur_pend ? code : SegBlank;
`ifdef CAR_ALARM_BLINK_EN
    if (cnt_q >= CntHalf) seg_d = SegBlank;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      door_q <= '0;
      btn_q  <= '0;
      pend_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      seg_q  <= SegBlank;
    end else begin
      door_q <= door;
      btn_q  <= btn;
      pend_q <= pend_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      seg_q  <= seg_d;
    end
  end

  assign bus.segment = seg_q;
  assign bus.alarm   = |pend_q;

endmodule

// File: tb/tb_car_alarm_display.sv
// Self-checking bench for car_alarm_display: directed vector table, reset/corner sequences,
// and randomized stimulus against a behavioural model (DWELL=8).
module tb_car_alarm_display;

  localparam int unsigned DWELL = 8;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001;
`ifdef CAR_ALARM_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  car_alarm_display_if bus ();
  car_alarm_display #(.DWELL(DWELL)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic [6:0] codes [5] = '{SF, SB, SE, SC, SD};

  // Behavioural model state
  logic [4:0] m_pend, m_door_prev, m_btn_prev;
  int         m_idx, m_cnt;
  logic [6:0] m_seg;

  typedef struct {
    logic [4:0] door;
    logic [4:0] btn;
    logic [6:0] seg;
    logic       alarm;
    bit         late;  // expected code falls in the second half of its dwell
  } vec_t;
  vec_t vecs [$];

  task automatic chk7(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  function automatic int next_pend(input logic [4:0] p, input int from);
    for (int k = 1; k <= 5; k++) begin
      if (p[(from + k) % 5]) return (from + k) % 5;
    end
    return from;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_door_prev = '0;
    m_btn_prev = '0;
    m_idx = 0;
    m_cnt = 0;
    m_seg = BLANK;
  endtask

  task automatic model_clock(input logic [4:0] d, input logic [4:0] b);
    logic [4:0] dr, br;
    if (m_pend[m_idx] && !(BLINK && m_cnt >= int'(DWELL / 2))) m_seg = codes[m_idx];
    else m_seg = BLANK;
    if (m_pend == 5'b0) begin
      m_cnt = 0;
    end else if (!m_pend[m_idx] || m_cnt == int'(DWELL) - 1) begin
      m_idx = next_pend(m_pend, m_idx);
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    dr = d & ~m_door_prev;
    br = b & ~m_btn_prev;
    m_pend = (m_pend | dr) & ~(br & ~dr);
    m_door_prev = d;
    m_btn_prev = b;
  endtask

  task automatic drive(input logic [4:0] d, input logic [4:0] b);
    bus.front1 = d[0]; bus.front2 = d[1]; bus.back1 = d[2]; bus.back2 = d[3]; bus.trunk = d[4];
    bus.bttnL  = b[0]; bus.bttnR  = b[1]; bus.bttnU = b[2]; bus.bttnD = b[3]; bus.bttnC = b[4];
  endtask

  // Apply inputs, clock once, update the model, return on the following falling edge.
  task automatic step(input logic [4:0] d, input logic [4:0] b);
    drive(d, b);
    @(posedge clk);
    if (rst) model_reset();
    else model_clock(d, b);
    @(negedge clk);
  endtask

  // Assert reset between edges and check that outputs clear without a clock.
  task automatic async_reset_check(input string name);
    #2 rst = 1'b1;
    #1;
    chk7({name, " seg"}, bus.segment, BLANK);
    chk1({name, " alarm"}, bus.alarm, 1'b0);
  endtask

  initial begin
    logic [4:0] rd, rb;
    logic [6:0] exp;

    vecs.push_back('{5'b00000, 5'b00000, BLANK, 1'b0, 1'b0});
    vecs.push_back('{5'b00001, 5'b00000, BLANK, 1'b1, 1'b0});
    vecs.push_back('{5'b00001, 5'b00000, SF, 1'b1, 1'b0});
    vecs.push_back('{5'b00001, 5'b00000, SF, 1'b1, 1'b0});
    vecs.push_back('{5'b10001, 5'b00000, SF, 1'b1, 1'b0});
    vecs.push_back('{5'b10001, 5'b00000, SF, 1'b1, 1'b0});
    vecs.push_back('{5'b10001, 5'b00000, SF, 1'b1, 1'b1});
    vecs.push_back('{5'b10001, 5'b00000, SF, 1'b1, 1'b1});
    vecs.push_back('{5'b10001, 5'b00000, SF, 1'b1, 1'b1});
    vecs.push_back('{5'b10001, 5'b00000, SF, 1'b1, 1'b1});
    vecs.push_back('{5'b10001, 5'b00000, SD, 1'b1, 1'b0});
    vecs.push_back('{5'b10001, 5'b10000, SD, 1'b1, 1'b0});
    vecs.push_back('{5'b10001, 5'b10000, BLANK, 1'b1, 1'b0});
    vecs.push_back('{5'b10001, 5'b10000, SF, 1'b1, 1'b0});
    vecs.push_back('{5'b10001, 5'b10001, SF, 1'b0, 1'b0});
    vecs.push_back('{5'b10001, 5'b10001, BLANK, 1'b0, 1'b0});
    vecs.push_back('{5'b10000, 5'b00000, BLANK, 1'b0, 1'b0});
    vecs.push_back('{5'b10001, 5'b00000, BLANK, 1'b1, 1'b0});
    vecs.push_back('{5'b10001, 5'b00000, SF, 1'b1, 1'b0});
    vecs.push_back('{5'b11001, 5'b01000, SF, 1'b1, 1'b0});
    vecs.push_back('{5'b11001, 5'b01000, SF, 1'b1, 1'b0});
    vecs.push_back('{5'b11001, 5'b01000, SF, 1'b1, 1'b0});
    vecs.push_back('{5'b11001, 5'b01000, SF, 1'b1, 1'b1});
    vecs.push_back('{5'b11001, 5'b01000, SF, 1'b1, 1'b1});
    vecs.push_back('{5'b11001, 5'b01000, SF, 1'b1, 1'b1});
    vecs.push_back('{5'b11001, 5'b01000, SF, 1'b1, 1'b1});
    vecs.push_back('{5'b11001, 5'b01000, SC, 1'b1, 1'b0});
    vecs.push_back('{5'b11001, 5'b01000, SC, 1'b1, 1'b0});

    model_reset();
    drive(5'b0, 5'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk7("reset seg", bus.segment, BLANK);
    chk1("reset alarm", bus.alarm, 1'b0);
    rst = 1'b0;

    // Directed table: rotation, acknowledge, re-latch, collision
    foreach (vecs[i]) begin
      step(vecs[i].door, vecs[i].btn);
      exp = (BLINK && vecs[i].late) ? BLANK : vecs[i].seg;
      chk7($sformatf("vec%0d seg", i), bus.segment, exp);
      chk1($sformatf("vec%0d alarm", i), bus.alarm, vecs[i].alarm);
    end

    // Mid-stream async reset, then idle until a door rises
    async_reset_check("midreset");
    step(5'b0, 5'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(5'b0, 5'b0);
      chk7("idle seg", bus.segment, BLANK);
      chk1("idle alarm", bus.alarm, 1'b0);
    end

    // Single door held for 40 cycles
    step(5'b00001, 5'b0);
    chk1("single alarm", bus.alarm, 1'b1);
    chk7("single seg", bus.segment, BLANK);
    for (int i = 0; i < 40; i++) begin
      step(5'b00001, 5'b0);
      exp = (BLINK && (i % 8) >= 4) ? BLANK : SF;
      chk7("single hold", bus.segment, exp);
      chk1("single hold alarm", bus.alarm, 1'b1);
    end

    // Trunk held open through reset is latched on release
    step(5'b10000, 5'b0);
    async_reset_check("trunkreset");
    step(5'b10000, 5'b0);
    step(5'b10000, 5'b0);
    rst = 1'b0;
    step(5'b10000, 5'b0);
    chk1("trunk alarm", bus.alarm, 1'b1);
    chk7("trunk seg0", bus.segment, BLANK);
    step(5'b10000, 5'b0);
    chk7("trunk seg1", bus.segment, BLANK);
    step(5'b10000, 5'b0);
    chk7("trunk seg2", bus.segment, SD);

    // Randomized stimulus against the model
    rd = 5'b10000;
    rb = 5'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(15) == 0) rd[b] = ~rd[b];
        if ($urandom_range(7) == 0) rb[b] = ~rb[b];
      end
      if ($urandom_range(499) == 0) begin
        async_reset_check("rand reset");
        step(rd, rb);
        rst = 1'b0;
      end
      step(rd, rb);
      chk7("rand seg", bus.segment, m_seg);
      chk1("rand alarm", bus.alarm, m_pend != 5'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/car_alarm_display.md
# car_alarm_display

Encoder side of the car door alarm display path. It samples the five door sensors and the five acknowledge buttons, and latches each newly opened door as pending. Pending doors are shown one at a time, round-robin, as a letter code on the active-low 7-segment bus. The block also drives a summary alarm line while any door is pending.

## Interface

Parameters:
- DWELL, default 16: clock cycles each pending door stays on the display before rotation. Legal range 2..2^24, even values only.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- front1  input  1  door 0 open level, synchronous to clk.
- front2  input  1  door 1 open level.
- back1  input  1  door 2 open level.
- back2  input  1  door 3 open level.
- trunk  input  1  door 4 open level.
- bttnL  input  1  acknowledge for door 0.
- bttnR  input  1  acknowledge for door 1.
- bttnU  input  1  acknowledge for door 2.
- bttnD  input  1  acknowledge for door 3.
- bttnC  input  1  acknowledge for door 4.
- segment  output  7  active-low segment pattern, registered.
- alarm  output  1  high while any door is pending; combinational OR of the pending register.

## Operation

- Codes by door index:
  - 0 (front1): F = 0001110
  - 1 (front2): B = 0000011
  - 2 (back1): E = 0000110
  - 3 (back2): C = 1000110
  - 4 (trunk): D = 0100001
  - Blank: 1111111
- Edge detection:
  - door_q[4:0] and btn_q[4:0] hold the previous-cycle inputs.
  - rise = input & ~q, computed per bit.
- Pending register pend[4:0]:
  - pend <= (pend | door_rise) & ~(btn_rise & ~door_rise).
  - A door rise and a button rise on the same bit in the same cycle: set wins.
  - A door still open after acknowledge does not re-latch until it closes and reopens.
- Rotation state: idx (0..4) and dwell counter cnt (0..DWELL-1).
  - pend == 0: idx holds, cnt <= 0.
  - pend != 0 and pend[idx] == 0: idx <= the next set bit found scanning idx+1, idx+2, … cyclically modulo 5; cnt <= 0.
  - pend[idx] == 1 and cnt < DWELL-1: cnt <= cnt+1.
  - pend[idx] == 1 and cnt == DWELL-1: cnt <= 0 and idx <= the next set bit after idx, cyclic. If idx is the only pending door, idx is reselected.
- Segment register:
  - segment <= pend[idx] ? code(idx) : blank, evaluated from the current-cycle registers.
  - This applies before any BLINK_EN masking.
- Reset values:
  - pend = 0, idx = 0, cnt = 0, door_q = 0, btn_q = 0.
  - segment = 1111111, alarm = 0.
- Because door_q resets to 0, a door held open through reset registers as a rise on the first edge after reset release.

## Timing

- Door input high before edge k:
  - pend bit set and alarm high after edge k.
  - If idx already points at that door: segment shows its code after edge k+1.
  - Otherwise: idx moves at edge k+1 and segment shows the code after edge k+2.
- Button rise before edge k:
  - pend bit clears at edge k.
  - segment blanks after edge k+1.
  - The next pending code appears after edge k+2.
- Steady rotation: each code is shown for exactly DWELL cycles, with no blank gap between consecutive doors.
- Reset assertion clears all registers and outputs immediately, independent of clk; this includes mid-dwell.
- Reset release: normal operation from the first rising edge with rst low.

## Configuration

- CAR_ALARM_BLINK_EN defined:
  - While a code is displayed, segment is forced blank when cnt >= DWELL/2.
  - Each door therefore flashes on for DWELL/2 cycles, then off for DWELL/2 cycles.
  - alarm is unaffected.
- CAR_ALARM_BLINK_EN undefined: the code is steady for the full dwell.

## Test plan

All scenarios use DWELL=8.
- Reset: assert rst mid-stream -> segment=1111111 and alarm=0 immediately, and they stay so until the first door rise after release.
- Single door: front1 0->1 before edge k -> alarm=1 after edge k, segment=0001110 after edge k+1, and it holds F continuously for 40 cycles.
- Rotation: front1 and trunk rise together -> F for 8 cycles, D for 8 cycles, F for 8 cycles, repeating.
- Acknowledge: bttnL rises while F is shown with trunk pending -> blank one cycle, then D steady; bttnC rise -> segment=1111111 and alarm=0.
- Collision and re-latch:
  - back2 and bttnD rise in the same cycle -> pend[3] stays set and C is displayed.
  - trunk held high through reset -> D is shown after release.
- Blink build (CAR_ALARM_BLINK_EN defined), back1 only -> 0000110 for 4 cycles, 1111111 for 4 cycles, repeating; alarm constant 1.
